// File: rtl/sobel_pipeline.sv
// Streaming 3x3 Sobel edge filter for raster-scan frames of WIDTH_P x HEIGHT_P pixels.
// One output per input, in raster order, registered. Output n is produced on the edge that
// accepts input n+WIDTH_P+1; after the last input of a frame the block flushes the remaining
// WIDTH_P+1 outputs (all border pixels) on consecutive cycles.
module sobel_pipeline #(
  parameter int unsigned WIDTH_P    = 640,
  parameter int unsigned HEIGHT_P   = 480,
  parameter int unsigned CHANNELS_P = 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    valid_i,
  input  logic [CHANNELS_P*8-1:0] pixel_i,
  output logic                    valid_o,
  output logic [CHANNELS_P*8-1:0] pixel_o
);

  localparam int unsigned PixW  = CHANNELS_P * 8;
  // Two rows of history plus two extra taps reach back to p[r-1][c-1].
  localparam int unsigned Depth = 2 * WIDTH_P + 2;
  localparam int unsigned ColW  = $clog2(WIDTH_P);
  localparam int unsigned RowW  = $clog2(HEIGHT_P);
  localparam logic [ColW-1:0] LastCol = ColW'(WIDTH_P - 1);
  localparam logic [RowW-1:0] LastRow = RowW'(HEIGHT_P - 1);

  // Window taps relative to the incoming pixel, which is p[r+1][c+1] of the output being made.
  localparam int unsigned TapNw = 2 * WIDTH_P + 1;
  localparam int unsigned TapN  = 2 * WIDTH_P;
  localparam int unsigned TapNe = 2 * WIDTH_P - 1;
  localparam int unsigned TapW  = WIDTH_P + 1;
  localparam int unsigned TapE  = WIDTH_P - 1;
  localparam int unsigned TapSw = 1;
  localparam int unsigned TapS  = 0;

  typedef enum logic [0:0] {StStream, StFlush} state_e;

  state_e          state_q, state_d;
  logic [ColW-1:0] in_col_q, in_col_d, out_col_q, out_col_d;
  logic [RowW-1:0] in_row_q, in_row_d, out_row_q, out_row_d;
  logic            valid_q;
  logic [PixW-1:0] pix_q;
  logic [PixW-1:0] dly_q [Depth];
  logic [PixW-1:0] filt;
  logic            accept, primed, emit, interior;

  // |gx| + |gy| saturated to 8 bits; 12-bit signed intermediates cover +/-1020.
  function automatic logic [7:0] sobel_mag(input logic [7:0] nw, n, ne, w, e, sw, s, se);
    logic [10:0]        pos_x, neg_x, pos_y, neg_y;
    logic signed [11:0] gx, gy;
    logic [10:0]        abs_x, abs_y;
    logic [11:0]        sum;
    pos_x = {3'b0, ne} + {2'b0, e, 1'b0} + {3'b0, se};
    neg_x = {3'b0, nw} + {2'b0, w, 1'b0} + {3'b0, sw};
    pos_y = {3'b0, sw} + {2'b0, s, 1'b0} + {3'b0, se};
    neg_y = {3'b0, nw} + {2'b0, n, 1'b0} + {3'b0, ne};
    gx    = $signed({1'b0, pos_x}) - $signed({1'b0, neg_x});
    gy    = $signed({1'b0, pos_y}) - $signed({1'b0, neg_y});
    abs_x = gx[11] ? 11'(-gx) : gx[10:0];
    abs_y = gy[11] ? 11'(-gy) : gy[10:0];
    sum   = {1'b0, abs_x} + {1'b0, abs_y};
    return (sum > 12'd255) ? 8'hFF : sum[7:0];
  endfunction

  // Next-state logic: input/output raster counters and the stream/flush FSM.
  always_comb begin
    state_d   = state_q;
    in_col_d  = in_col_q;
    in_row_d  = in_row_q;
    out_col_d = out_col_q;
    out_row_d = out_row_q;
    accept    = (state_q == StStream) && valid_i;
    // Outputs start once input index WIDTH_P+1 (row 1, col 1) arrives.
    primed    = (in_row_q > RowW'(1)) || ((in_row_q == RowW'(1)) && (in_col_q != '0));
    emit      = (state_q == StFlush) || (accept && primed);
    interior  = (out_row_q != '0) && (out_row_q != LastRow) &&
                (out_col_q != '0) && (out_col_q != LastCol);

    if (accept) begin
      if (in_col_q == LastCol) begin
        in_col_d = '0;
        if (in_row_q == LastRow) begin
          in_row_d = '0;
          state_d  = StFlush;
        end else begin
          in_row_d = in_row_q + RowW'(1);
        end
      end else begin
        in_col_d = in_col_q + ColW'(1);
      end
    end

    if (emit) begin
      if (out_col_q == LastCol) begin
        out_col_d = '0;
        if (out_row_q == LastRow) begin
          out_row_d = '0;
          state_d   = StStream;
        end else begin
          out_row_d = out_row_q + RowW'(1);
        end
      end else begin
        out_col_d = out_col_q + ColW'(1);
      end
    end
  end

  // Per-channel Sobel magnitude over the current window.
  always_comb begin
    filt = '0;
    for (int k = 0; k < int'(CHANNELS_P); k++) begin
      filt[8*k +: 8] = sobel_mag(dly_q[TapNw][8*k +: 8], dly_q[TapN][8*k +: 8],
                                 dly_q[TapNe][8*k +: 8], dly_q[TapW][8*k +: 8],
                                 dly_q[TapE][8*k +: 8], dly_q[TapSw][8*k +: 8],
                                 dly_q[TapS][8*k +: 8], pixel_i[8*k +: 8]);
    end
  end

  // Line-buffer shift on each accepted pixel; contents need no reset since borders mask them.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      dly_q[0] <= pixel_i;
      for (int i = 1; i < int'(Depth); i++) begin
        dly_q[i] <= dly_q[i-1];
      end
    end
  end

  // Control state and registered output; pixel_o holds between outputs.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= StStream;
      in_col_q  <= '0;
      in_row_q  <= '0;
      out_col_q <= '0;
      out_row_q <= '0;
      valid_q   <= 1'b0;
      pix_q     <= '0;
    end else begin
      state_q   <= state_d;
      in_col_q  <= in_col_d;
      in_row_q  <= in_row_d;
      out_col_q <= out_col_d;
      out_row_q <= out_row_d;
      valid_q   <= emit;
      if (emit) begin
        pix_q <= interior ? filt : '0;
      end
    end
  end

  assign valid_o = valid_q;
  assign pixel_o = pix_q;

endmodule

// File: tb/tb_sobel_pipeline.sv
// Bench for sobel_pipeline: a 1-channel and a 3-channel instance share the stimulus; every
// output value and its arrival cycle is checked against a frame-level arithmetic model.
module tb_sobel_pipeline;

  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid;
  logic [23:0] pix3;
  logic        v1, v3;
  logic [7:0]  po1;
  logic [23:0] po3;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [23:0] img [H][W];
  int          acc_cyc [N];
  logic [7:0]  q1 [$];
  logic [23:0] q3 [$];
  int          qc1 [$];
  int          qc3 [$];

  always #5 clk = ~clk;

  sobel_pipeline #(.WIDTH_P(W), .HEIGHT_P(H), .CHANNELS_P(1)) dut1 (
    .clk_i(clk), .reset_i(reset_n), .valid_i(valid), .pixel_i(pix3[7:0]),
    .valid_o(v1), .pixel_o(po1)
  );

  sobel_pipeline #(.WIDTH_P(W), .HEIGHT_P(H), .CHANNELS_P(3)) dut3 (
    .clk_i(clk), .reset_i(reset_n), .valid_i(valid), .pixel_i(pix3),
    .valid_o(v3), .pixel_o(po3)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Collect outputs with the index of the edge that registered them.
  always @(negedge clk) begin
    if (v1 === 1'b1) begin q1.push_back(po1); qc1.push_back(cyc); end
    if (v3 === 1'b1) begin q3.push_back(po3); qc3.push_back(cyc); end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // 0 const 100, 1 vertical step, 2 horizontal ramp, 3 vertical ramp, else random.
  // Channels 1-2 carry a per-frame constant except in random frames.
  task automatic build_frame(input int mode);
    logic [7:0] bg1, bg2, c0;
    bg1 = 8'($urandom_range(0, 255));
    bg2 = 8'($urandom_range(0, 255));
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        case (mode)
          0:       c0 = 8'd100;
          1:       c0 = (c >= W / 2) ? 8'd255 : 8'd0;
          2:       c0 = 8'(c);
          3:       c0 = 8'(10 * r);
          default: c0 = 8'($urandom_range(0, 255));
        endcase
        img[r][c] = (mode < 4) ? {bg2, bg1, c0} : 24'($urandom());
      end
    end
  endtask

  function automatic int px(int r, int c, int ch);
    return (int'(img[r][c]) >> (8 * ch)) & 255;
  endfunction

  function automatic int ref_ch(int r, int c, int ch);
    int gx, gy, mag;
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 0;
    gx = (px(r-1, c+1, ch) + 2 * px(r, c+1, ch) + px(r+1, c+1, ch))
       - (px(r-1, c-1, ch) + 2 * px(r, c-1, ch) + px(r+1, c-1, ch));
    gy = (px(r+1, c-1, ch) + 2 * px(r+1, c, ch) + px(r+1, c+1, ch))
       - (px(r-1, c-1, ch) + 2 * px(r-1, c, ch) + px(r-1, c+1, ch));
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (mag > 255) ? 255 : mag;
  endfunction

  function automatic int ref_pix3(int n);
    int r, c;
    r = n / W;
    c = n % W;
    return (ref_ch(r, c, 2) << 16) | (ref_ch(r, c, 1) << 8) | ref_ch(r, c, 0);
  endfunction

  // gap: 0 back-to-back, 1 one idle cycle per pixel, 2 random idles,
  // 3 back-to-back with valid held high through the flush (must be discarded).
  task automatic run_frame(input int mode, input int gap, input string name);
    int t, g, last, exp_c, lim;
    build_frame(mode);
    q1.delete(); q3.delete(); qc1.delete(); qc3.delete();
    for (int n = 0; n < N; n++) begin
      valid = 1'b1;
      pix3  = img[n / W][n % W];
      @(posedge clk); #1;
      acc_cyc[n] = cyc;
      valid = 1'b0;
      pix3  = 24'($urandom());
      g = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (g) begin @(posedge clk); #1; end
    end
    if (gap == 3) begin
      valid = 1'b1;
      repeat (W + 1) begin pix3 = 24'($urandom()); @(posedge clk); #1; end
      valid = 1'b0;
    end
    t = 0;
    while (q1.size() < N && t < 100) begin @(posedge clk); #1; t++; end
    repeat (8) begin @(posedge clk); #1; end
    check($sformatf("%s count1", name), q1.size(), N);
    check($sformatf("%s count3", name), q3.size(), N);
    last = acc_cyc[N - 1];
    lim = (q1.size() < q3.size()) ? q1.size() : q3.size();
    if (lim > N) lim = N;
    for (int n = 0; n < lim; n++) begin
      exp_c = (n + W + 1 < N) ? acc_cyc[n + W + 1] : last + (n - (N - W - 2));
      check($sformatf("%s val1[%0d]", name, n), q1[n], ref_ch(n / W, n % W, 0));
      check($sformatf("%s val3[%0d]", name, n), q3[n], ref_pix3(n));
      check($sformatf("%s cyc1[%0d]", name, n), qc1[n], exp_c);
      check($sformatf("%s cyc3[%0d]", name, n), qc3[n], exp_c);
    end
  endtask

  // Feed part of a frame, then pulse reset between clock edges.
  task automatic partial_reset(input int mode, input int npix);
    int no;
    build_frame(mode);
    for (int n = 0; n < npix; n++) begin
      valid = 1'b1;
      pix3  = img[n / W][n % W];
      @(posedge clk); #1;
    end
    valid = 1'b0;
    no = npix - W - 2;
    check("pre-reset valid", v1, 1);
    check("pre-reset pixel", po1, ref_ch(no / W, no % W, 0));
    #3;
    reset_n = 1'b0;
    #1;
    check("async reset valid1", v1, 0);
    check("async reset pixel1", po1, 0);
    check("async reset valid3", v3, 0);
    check("async reset pixel3", po3, 0);
    #2;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    valid   = 1'b0;
    pix3    = '0;
    #17;
    check("reset valid1", v1, 0);
    check("reset pixel1", po1, 0);
    check("reset valid3", v3, 0);
    check("reset pixel3", po3, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_frame(0, 0, "const");
    run_frame(1, 0, "vstep");
    run_frame(2, 0, "hramp");
    run_frame(3, 0, "vramp");
    run_frame(1, 1, "vstep_toggle");
    run_frame(4, 2, "rand_gaps");
    run_frame(4, 3, "rand_flushnoise");
    run_frame(4, 0, "rand_after_noise");
    partial_reset(4, 7);
    run_frame(1, 0, "vstep_after_reset");
    partial_reset(1, 11);
    run_frame(4, 1, "rand_toggle");
    run_frame(1, 2, "vstep_gaps");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
